// File: rtl/iir_sos_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : iir_sos_engine_if
//  Description : Sample-in / sample-out valid-ready stream bundle for the
//                biquad cascade engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface iir_sos_engine_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y_out;

    // Engine side: consumes x_in, produces y_out
    modport slave (
        input  in_valid,
        input  x_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y_out
    );

    // Producer / consumer side
    modport master (
        output in_valid,
        output x_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y_out
    );
endinterface
`default_nettype wire

// File: rtl/iir_sos_engine.sv
`default_nettype none
// ============================================================================
//  Module      : iir_sos_engine
//  Description : Time-multiplexed Direct Form I biquad cascade. One section is
//                evaluated per cycle using coefficients read combinationally
//                from an external ROM addressed by stage_index.
//  Revision    : 1.0  initial release
// ============================================================================
module iir_sos_engine #(
    parameter int N_STAGES = 6,
    parameter int DW       = 16,
    parameter int CW       = 16,
    parameter int FRAC     = 14,
    parameter int ACCW     = 40
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 clear,
    iir_sos_engine_if.slave           bus,
    output logic [2:0]                stage_index,
    input  wire logic signed [CW-1:0] b0,
    input  wire logic signed [CW-1:0] b1,
    input  wire logic signed [CW-1:0] b2,
    input  wire logic signed [CW-1:0] a1,
    input  wire logic signed [CW-1:0] a2,
    output logic                      sat_flag
);

    localparam int PW = CW + DW;

    localparam logic [2:0] c_LAST = 3'(N_STAGES - 1);
    // Half an LSB of the output, added before the arithmetic shift (round half up)
    localparam logic signed [ACCW-1:0] c_RND  = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACCW-1:0] c_YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic signed [DW-1:0]  r_s;
    logic signed [DW-1:0]  r_x1 [N_STAGES];
    logic signed [DW-1:0]  r_x2 [N_STAGES];
    logic signed [DW-1:0]  r_y1 [N_STAGES];
    logic signed [DW-1:0]  r_y2 [N_STAGES];
    logic [DW-1:0]         r_y_out;
    logic                  r_out_valid;
    logic                  r_sat;

    logic signed [PW-1:0]   w_p0, w_p1, w_p2, w_pa1, w_pa2;
    logic signed [ACCW-1:0] w_acc;
    logic signed [ACCW-1:0] w_r;
    logic                   w_hi, w_lo;
    logic signed [DW-1:0]   w_y;

    // Section datapath for the section currently addressed by r_cnt
    assign w_p0  = b0 * r_s;
    assign w_p1  = b1 * r_x1[r_cnt];
    assign w_p2  = b2 * r_x2[r_cnt];
    assign w_pa1 = a1 * r_y1[r_cnt];
    assign w_pa2 = a2 * r_y2[r_cnt];

    // Products are sign-extended to the accumulator width so the sum never wraps
    assign w_acc = {{(ACCW-PW){w_p0[PW-1]}},  w_p0}
                 + {{(ACCW-PW){w_p1[PW-1]}},  w_p1}
                 + {{(ACCW-PW){w_p2[PW-1]}},  w_p2}
                 - {{(ACCW-PW){w_pa1[PW-1]}}, w_pa1}
                 - {{(ACCW-PW){w_pa2[PW-1]}}, w_pa2};

    assign w_r  = (w_acc + c_RND) >>> FRAC;
    assign w_hi = (w_r > c_YMAX);
    assign w_lo = (w_r < c_YMIN);
    assign w_y  = w_hi ? c_YMAX[DW-1:0] : (w_lo ? c_YMIN[DW-1:0] : w_r[DW-1:0]);

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.y_out     = r_y_out;
    // r_cnt is held at zero outside RUN, so it doubles as the ROM address
    assign stage_index   = r_cnt;
    assign sat_flag      = r_sat;

    // Control FSM, per-stage history and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_s         <= '0;
            r_y_out     <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            for (int i = 0; i < N_STAGES; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // clear wins over a pending sample
                    if (clear) begin
                        r_sat <= 1'b0;
                        for (int i = 0; i < N_STAGES; i++) begin
                            r_x1[i] <= '0;
                            r_x2[i] <= '0;
                            r_y1[i] <= '0;
                            r_y2[i] <= '0;
                        end
                    end else if (bus.in_valid) begin
                        r_s     <= bus.x_in;
                        r_cnt   <= 3'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x2[r_cnt] <= r_x1[r_cnt];
                    r_x1[r_cnt] <= r_s;
                    r_y2[r_cnt] <= r_y1[r_cnt];
                    r_y1[r_cnt] <= w_y;
                    r_s         <= w_y;
                    if (w_hi || w_lo) begin
                        r_sat <= 1'b1;
                    end
                    if (r_cnt == c_LAST) begin
                        r_y_out     <= w_y;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 3'd0;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
